// File: rtl/regfile_pkg.sv
// Shared sizing and types for the register file.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: default data width, register count, derived index width and
// the register-index type used on the writenum/readnum ports.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_dec.sv
// Binary to one-hot decoder, n inputs to 2^n outputs.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   bin  - binary index, N bits
//   hot  - one-hot output, bit[bin] set, all others clear
module regfile_dec #(
    parameter int N = regfile_pkg::ADDR_W
) (
    input  logic [N-1:0]      bin,
    output logic [(1<<N)-1:0] hot
);

    always_comb begin
        hot      = '0;
        hot[bin] = 1'b1;
    end

endmodule

// File: rtl/regfile.sv
// Register file: NUM_REGS x DATA_W, one write port, one combinational read port.
// Latency: write lands on the rising clk edge; read is zero-cycle combinational.
// Backpressure: none; a write is accepted on every edge where write=1.
//
// Ports:
//   clk      - rising-edge clock for all register updates
//   rst_n    - asynchronous active-low clear of every register
//   data_in  - full-width write data, stored bit-exact
//   writenum - target register index
//   write    - write enable
//   readnum  - source register index for data_out
//   data_out - contents of R[readnum]; no write-through bypass
module regfile #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  regfile_pkg::reg_idx_t writenum,
    input  logic                  write,
    input  regfile_pkg::reg_idx_t readnum,
    output logic [DATA_W-1:0]     data_out
);

    import regfile_pkg::*;

    localparam int DEC_W = 1 << ADDR_W;

    logic [DEC_W-1:0]  wr_hot;
    logic [DEC_W-1:0]  rd_hot;
    logic [DEC_W-1:0]  load_en;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Same decoder serves both ports: write-enable generation and the
    // one-hot read select.
    regfile_dec #(.N(ADDR_W)) u_wr_dec (
        .bin (writenum),
        .hot (wr_hot)
    );

    regfile_dec #(.N(ADDR_W)) u_rd_dec (
        .bin (readnum),
        .hot (rd_hot)
    );

    // Gating the one-hot vector with write keeps at most one load active,
    // and none at all when write is low.
    assign load_en = wr_hot & {DEC_W{write}};

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (load_en[i]) begin
                regs[i] <= data_in;
            end
        end
    end

    // AND-OR mux: each register is masked by its select bit and the results
    // are ORed. With a one-hot select this yields exactly R[readnum], and
    // reads 0 while reset holds every register clear.
    always_comb begin
        data_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            data_out = data_out | (regs[i] & {DATA_W{rd_hot[i]}});
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile;

    localparam int DW = 16;
    localparam int NR = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [2:0]    writenum;
    logic          write;
    logic [2:0]    readnum;
    logic [DW-1:0] data_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] exp_mem [NR];

    regfile #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .writenum (writenum),
        .write    (write),
        .readnum  (readnum),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a write at the falling edge, let it land on the next rising edge,
    // then drop write 1 ns later.
    task automatic do_write(input logic [2:0] idx, input logic [DW-1:0] val);
        @(negedge clk);
        writenum = idx;
        data_in  = val;
        write    = 1'b1;
        @(posedge clk);
        #1;
        write    = 1'b0;
        exp_mem[idx] = val;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        write    = 1'b0;
        writenum = 3'd0;
        readnum  = 3'd0;
        data_in  = '0;
        for (int i = 0; i < NR; i++) exp_mem[i] = '0;
        #2;
        for (int i = 0; i < NR; i++) begin
            readnum = 3'(i);
            #1;
            total_cnt++;
            if (data_out !== 16'h0000)
                $display("FAIL reset_read R%0d: got %h expected 0000", i, data_out);
            else pass_cnt++;
        end
        // Writes while held in reset must be ignored.
        @(negedge clk);
        writenum = 3'd2;
        data_in  = 16'hABCD;
        write    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        write   = 1'b0;
        readnum = 3'd2;
        #1;
        total_cnt++;
        if (data_out !== 16'h0000)
            $display("FAIL reset_write_ignored: got %h expected 0000", data_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] vals [NR];
        logic [2:0]    order [NR];
        vals  = '{16'hC728, 16'h528B, 16'h002A, 16'hA76A,
                  16'h35C0, 16'h0EFF, 16'h0001, 16'h7F00};
        order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int k = 0; k < NR; k++) begin
            do_write(order[k], vals[k]);
            readnum = order[k];
            #1;
            total_cnt++;
            if (data_out !== vals[k])
                $display("FAIL write_read R%0d: got %h expected %h", order[k], data_out, vals[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fill_scan();
        logic [DW-1:0] vals [NR];
        logic [2:0]    order [NR];
        vals  = '{16'hAA2A, 16'h2E72, 16'h7334, 16'hFC55,
                  16'h3573, 16'h9176, 16'h850F, 16'h2A4A};
        order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        // Consecutive edges: write stays high, only index/data change.
        @(negedge clk);
        write = 1'b1;
        for (int k = 0; k < NR; k++) begin
            writenum = order[k];
            data_in  = vals[k];
            @(negedge clk);
        end
        write = 1'b0;
        for (int k = 0; k < NR; k++) begin
            readnum = order[k];
            #1;
            total_cnt++;
            if (data_out !== vals[k])
                $display("FAIL fill_scan R%0d: got %h expected %h", order[k], data_out, vals[k]);
            else pass_cnt++;
            exp_mem[order[k]] = vals[k];
        end
    endtask

    task automatic test_write_disabled();
        @(negedge clk);
        write    = 1'b0;
        writenum = 3'd3;
        data_in  = 16'hFFFF;
        // A write pulse that rises and falls between edges must not land.
        #1 write = 1'b1;
        #2 write = 1'b0;
        writenum = 3'd6;
        data_in  = 16'h0BAD;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            readnum = 3'(i);
            #1;
            total_cnt++;
            if (data_out !== exp_mem[i])
                $display("FAIL write_disabled R%0d: got %h expected %h", i, data_out, exp_mem[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_same_index();
        do_write(3'd5, 16'h1234);
        @(negedge clk);
        readnum  = 3'd5;
        writenum = 3'd5;
        data_in  = 16'hBEEF;
        write    = 1'b1;
        #1;
        total_cnt++;
        if (data_out !== 16'h1234)
            $display("FAIL same_index_before: got %h expected 1234", data_out);
        else pass_cnt++;
        @(posedge clk);
        #1;
        write = 1'b0;
        total_cnt++;
        if (data_out !== 16'hBEEF)
            $display("FAIL same_index_after: got %h expected BEEF", data_out);
        else pass_cnt++;
        exp_mem[5] = 16'hBEEF;
        // Read and write different registers in the same cycle.
        @(negedge clk);
        readnum  = 3'd1;
        writenum = 3'd7;
        data_in  = 16'h5A5A;
        write    = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
        total_cnt++;
        if (data_out !== 16'hAA2A)
            $display("FAIL indep_read R1: got %h expected AA2A", data_out);
        else pass_cnt++;
        readnum = 3'd7;
        #1;
        total_cnt++;
        if (data_out !== 16'h5A5A)
            $display("FAIL indep_write R7: got %h expected 5A5A", data_out);
        else pass_cnt++;
        exp_mem[7] = 16'h5A5A;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            exp_mem[i] = '0;
            readnum = 3'(i);
            #1;
            total_cnt++;
            if (data_out !== 16'h0000)
                $display("FAIL async_reset R%0d: got %h expected 0000", i, data_out);
            else pass_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_write(3'd2, 16'h0042);
        for (int i = 0; i < NR; i++) begin
            readnum = 3'(i);
            #1;
            total_cnt++;
            if (data_out !== ((i == 2) ? 16'h0042 : 16'h0000))
                $display("FAIL post_reset R%0d: got %h expected %h", i, data_out,
                         (i == 2) ? 16'h0042 : 16'h0000);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_coincident_write();
        @(negedge clk);
        writenum = 3'd4;
        data_in  = 16'h5555;
        write    = 1'b1;
        readnum  = 3'd4;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        write = 1'b0;
        total_cnt++;
        if (data_out !== 16'h0000)
            $display("FAIL reset_vs_write R4: got %h expected 0000", data_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        // First write after release behaves normally.
        do_write(3'd4, 16'h9001);
        total_cnt++;
        if (data_out !== 16'h9001)
            $display("FAIL first_write_after_reset R4: got %h expected 9001", data_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fill_scan();
        test_write_disabled();
        test_same_index();
        test_async_reset();
        test_reset_coincident_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
